// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and enums for the issue stage and its decoder.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_XOR  = 3'b100,
        ALU_NONE = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_I    = 2'd1,
        IMM_S    = 2'd2,
        IMM_B    = 2'd3
    } imm_sel_t;

    // Formats whose rs2 field is a real source register (matters for hazards).
    function automatic logic reads_rs2(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// ID/EX slot bundle: the issue stage drives it, the execute stage consumes it.
interface alu_issue_stage_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  SrcA;
    logic [WIDTH-1:0]  SrcB;
    logic [2:0]        ALUctrl;
    logic [WIDTH-1:0]  WriteData;
    logic [WIDTH-1:0]  ImmExt;
    logic [WIDTH-1:0]  pc_out;
    logic [ADDR_W-1:0] rd_addr;
    logic              RegWrite;
    logic              MemWrite;
    logic              MemRead;
    logic              Branch;
    logic              BranchNe;
    logic              illegal;

    modport master (
        output out_valid, SrcA, SrcB, ALUctrl, WriteData, ImmExt, pc_out,
               rd_addr, RegWrite, MemWrite, MemRead, Branch, BranchNe, illegal,
        input  out_ready
    );

    modport slave (
        input  out_valid, SrcA, SrcB, ALUctrl, WriteData, ImmExt, pc_out,
               rd_addr, RegWrite, MemWrite, MemRead, Branch, BranchNe, illegal,
        output out_ready
    );
endinterface

// File: rtl/riscv_decoder.sv
// Combinational decoder for the supported RV32I ALU/load/store/branch subset.
module riscv_decoder
    import riscv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic [31:0]       instr,
    output logic [ADDR_W-1:0] rs1,
    output logic [ADDR_W-1:0] rs2,
    output logic [ADDR_W-1:0] rd,
    output alu_op_t           alu_ctrl,
    output imm_sel_t          imm_sel,
    output logic [WIDTH-1:0]  imm_ext,
    output logic              reg_write,
    output logic              mem_write,
    output logic              mem_read,
    output logic              branch,
    output logic              branch_ne,
    output logic              illegal,
    output logic              uses_rs2
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       writes_rd;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign rd       = instr[11:7];
    assign uses_rs2 = reads_rs2(opcode);

    // Classify the encoding; anything unmatched falls through as illegal with no side effects.
    always_comb begin
        alu_ctrl  = ALU_NONE;
        imm_sel   = IMM_NONE;
        writes_rd = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        illegal   = 1'b1;
        case (opcode)
            OP_R: begin
                if (funct3 == F3_ADD_SUB && funct7 == F7_BASE) begin
                    alu_ctrl = ALU_ADD;
                    illegal  = 1'b0;
                end else if (funct3 == F3_ADD_SUB && funct7 == F7_SUB) begin
                    alu_ctrl = ALU_SUB;
                    illegal  = 1'b0;
                end else if (funct3 == F3_XOR && funct7 == F7_BASE) begin
                    alu_ctrl = ALU_XOR;
                    illegal  = 1'b0;
                end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
                    alu_ctrl = ALU_AND;
                    illegal  = 1'b0;
                end
                writes_rd = !illegal;
            end
            OP_I: begin
                imm_sel = IMM_I;
                case (funct3)
                    F3_ADD_SUB: begin alu_ctrl = ALU_ADD; illegal = 1'b0; end
                    F3_XOR:     begin alu_ctrl = ALU_XOR; illegal = 1'b0; end
                    F3_AND:     begin alu_ctrl = ALU_AND; illegal = 1'b0; end
                    default:    ;
                endcase
                writes_rd = !illegal;
            end
            OP_LOAD: begin
                imm_sel = IMM_I;
                if (funct3 == F3_LW) begin
                    alu_ctrl  = ALU_ADD;
                    mem_read  = 1'b1;
                    writes_rd = 1'b1;
                    illegal   = 1'b0;
                end
            end
            OP_STORE: begin
                imm_sel = IMM_S;
                if (funct3 == F3_SW) begin
                    alu_ctrl  = ALU_ADD;
                    mem_write = 1'b1;
                    illegal   = 1'b0;
                end
            end
            OP_BRANCH: begin
                imm_sel = IMM_B;
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    alu_ctrl  = ALU_SUB;
                    branch    = 1'b1;
                    branch_ne = (funct3 == F3_BNE);
                    illegal   = 1'b0;
                end
            end
            default: ;
        endcase
        if (illegal) begin
            imm_sel = IMM_NONE;
        end
    end

    // x0 is hardwired, so a write to it is suppressed at decode.
    assign reg_write = writes_rd && (rd != '0);

    // Immediate assembly per format, sign-extended to the datapath width.
    always_comb begin
        imm_ext = '0;
        case (imm_sel)
            IMM_I:   imm_ext = {{(WIDTH-12){instr[31]}}, instr[31:20]};
            IMM_S:   imm_ext = {{(WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm_ext = {{(WIDTH-13){instr[31]}}, instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0};
            default: imm_ext = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes the fetched instruction, checks for a load-use
// hazard against the slot, and registers operands/controls into the ID/EX slot.
module alu_issue_stage
    import riscv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [WIDTH-1:0]  pc_in,
    output logic [ADDR_W-1:0] rs1_addr,
    output logic [ADDR_W-1:0] rs2_addr,
    input  logic [WIDTH-1:0]  rd1,
    input  logic [WIDTH-1:0]  rd2,
    input  logic              flush,
    alu_issue_stage_if.master ex
);

    logic [ADDR_W-1:0] dec_rd;
    alu_op_t           dec_alu;
    imm_sel_t          dec_imm_sel;
    logic [WIDTH-1:0]  dec_imm;
    logic              dec_reg_write;
    logic              dec_mem_write;
    logic              dec_mem_read;
    logic              dec_branch;
    logic              dec_branch_ne;
    logic              dec_illegal;
    logic              dec_uses_rs2;
    logic [WIDTH-1:0]  src_b;
    logic              advance;
    logic              hazard;

    riscv_decoder #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_decoder (
        .instr     (instr),
        .rs1       (rs1_addr),
        .rs2       (rs2_addr),
        .rd        (dec_rd),
        .alu_ctrl  (dec_alu),
        .imm_sel   (dec_imm_sel),
        .imm_ext   (dec_imm),
        .reg_write (dec_reg_write),
        .mem_write (dec_mem_write),
        .mem_read  (dec_mem_read),
        .branch    (dec_branch),
        .branch_ne (dec_branch_ne),
        .illegal   (dec_illegal),
        .uses_rs2  (dec_uses_rs2)
    );

    // R-type has no immediate and branches compare two registers, so both take rd2.
    assign src_b = (dec_imm_sel == IMM_NONE || dec_imm_sel == IMM_B) ? rd2 : dec_imm;

    assign advance = !ex.out_valid || ex.out_ready;

    // A load in the slot cannot forward its data in time to the next instruction.
    assign hazard = in_valid && ex.out_valid && ex.MemRead && (ex.rd_addr != '0) &&
                    ((ex.rd_addr == rs1_addr) || (dec_uses_rs2 && ex.rd_addr == rs2_addr));

    assign in_ready = advance && !hazard && !flush;

    // ID/EX slot: reset, kill, bubble, load, or hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex.out_valid <= 1'b0;
            ex.SrcA      <= '0;
            ex.SrcB      <= '0;
            ex.ALUctrl   <= '0;
            ex.WriteData <= '0;
            ex.ImmExt    <= '0;
            ex.pc_out    <= '0;
            ex.rd_addr   <= '0;
            ex.RegWrite  <= 1'b0;
            ex.MemWrite  <= 1'b0;
            ex.MemRead   <= 1'b0;
            ex.Branch    <= 1'b0;
            ex.BranchNe  <= 1'b0;
            ex.illegal   <= 1'b0;
        end else if (flush || (advance && (hazard || !in_valid))) begin
            ex.out_valid <= 1'b0;
            ex.RegWrite  <= 1'b0;
            ex.MemWrite  <= 1'b0;
            ex.MemRead   <= 1'b0;
            ex.Branch    <= 1'b0;
            ex.BranchNe  <= 1'b0;
            ex.illegal   <= 1'b0;
        end else if (advance) begin
            ex.out_valid <= 1'b1;
            ex.SrcA      <= rd1;
            ex.SrcB      <= src_b;
            ex.ALUctrl   <= dec_alu;
            ex.WriteData <= rd2;
            ex.ImmExt    <= dec_imm;
            ex.pc_out    <= pc_in;
            ex.rd_addr   <= dec_rd;
            ex.RegWrite  <= dec_reg_write;
            ex.MemWrite  <= dec_mem_write;
            ex.MemRead   <= dec_mem_read;
            ex.Branch    <= dec_branch;
            ex.BranchNe  <= dec_branch_ne;
            ex.illegal   <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed cases then randomized traffic.
module tb_alu_issue_stage;

    typedef struct {
        logic [31:0] srca, srcb, wdata, imm, pc;
        logic [2:0]  alu;
        logic [4:0]  rd;
        logic        rw, mw, mr, br, bne, ill;
        logic        chk_srcb, chk_imm, chk_rd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        flush;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t pend;
    logic exp_accept = 1'b0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    alu_issue_stage_if #(.WIDTH(32), .ADDR_W(5)) bus ();

    alu_issue_stage #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .pc_in    (pc_in),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rd1      (rd1),
        .rd2      (rd2),
        .flush    (flush),
        .ex       (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference: name the instruction, then derive every field from its mnemonic.
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] pc);
        exp_t e;
        string mn;
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        mn  = "ill";
        if      (opc == 7'h33 && f3 == 3'd0 && f7 == 7'h00) mn = "add";
        else if (opc == 7'h33 && f3 == 3'd0 && f7 == 7'h20) mn = "sub";
        else if (opc == 7'h33 && f3 == 3'd4 && f7 == 7'h00) mn = "xor";
        else if (opc == 7'h33 && f3 == 3'd7 && f7 == 7'h00) mn = "and";
        else if (opc == 7'h13 && f3 == 3'd0) mn = "addi";
        else if (opc == 7'h13 && f3 == 3'd4) mn = "xori";
        else if (opc == 7'h13 && f3 == 3'd7) mn = "andi";
        else if (opc == 7'h03 && f3 == 3'd2) mn = "lw";
        else if (opc == 7'h23 && f3 == 3'd2) mn = "sw";
        else if (opc == 7'h63 && f3 == 3'd0) mn = "beq";
        else if (opc == 7'h63 && f3 == 3'd1) mn = "bne";

        e.srca     = a;
        e.wdata    = b;
        e.pc       = pc;
        e.rd       = w[11:7];
        e.ill      = (mn == "ill");
        e.mw       = (mn == "sw");
        e.mr       = (mn == "lw");
        e.br       = (mn == "beq") || (mn == "bne");
        e.bne      = (mn == "bne");
        e.chk_imm  = 1'b1;
        e.chk_srcb = 1'b1;
        e.chk_rd   = 1'b0;
        e.rw       = 1'b0;
        e.imm      = 32'h0;
        e.srcb     = b;
        case (mn)
            "add", "addi", "lw", "sw": e.alu = 3'b000;
            "sub", "beq", "bne":       e.alu = 3'b001;
            "and", "andi":             e.alu = 3'b010;
            "xor", "xori":             e.alu = 3'b100;
            default:                   e.alu = 3'b111;
        endcase
        case (mn)
            "addi", "xori", "andi", "lw": e.imm = 32'($signed(w[31:20]));
            "sw":          e.imm = 32'($signed({w[31:25], w[11:7]}));
            "beq", "bne":  e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            default:       e.chk_imm = 1'b0;
        endcase
        case (mn)
            "add", "sub", "xor", "and", "beq", "bne": e.srcb = b;
            "addi", "xori", "andi", "lw", "sw":       e.srcb = e.imm;
            default:                                  e.chk_srcb = 1'b0;
        endcase
        case (mn)
            "add", "sub", "xor", "and", "addi", "xori", "andi", "lw": begin
                e.chk_rd = 1'b1;
                e.rw     = (w[11:7] != 5'd0);
            end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: compare the slot with the scoreboard head, predict in_ready, retire.
    always @(negedge clk) begin
        exp_t s;
        logic slotv;
        logic haz;
        logic u2;
        logic exp_rdy;
        slotv = (q.size() != 0);
        chk("out_valid", 32'(bus.out_valid), 32'(slotv));
        if (slotv) begin
            s = q[0];
            chk("SrcA", bus.SrcA, s.srca);
            chk("WriteData", bus.WriteData, s.wdata);
            chk("pc_out", bus.pc_out, s.pc);
            chk("ALUctrl", 32'(bus.ALUctrl), 32'(s.alu));
            chk("ctrl{rw,mw,mr,br,bne,ill}",
                32'({bus.RegWrite, bus.MemWrite, bus.MemRead, bus.Branch, bus.BranchNe, bus.illegal}),
                32'({s.rw, s.mw, s.mr, s.br, s.bne, s.ill}));
            if (s.chk_srcb) chk("SrcB", bus.SrcB, s.srcb);
            if (s.chk_imm)  chk("ImmExt", bus.ImmExt, s.imm);
            if (s.chk_rd)   chk("rd_addr", 32'(bus.rd_addr), 32'(s.rd));
        end
        if (rst) begin
            exp_accept = 1'b0;
        end else begin
            chk("rs1_addr", 32'(rs1_addr), 32'(instr[19:15]));
            chk("rs2_addr", 32'(rs2_addr), 32'(instr[24:20]));
            u2  = (instr[6:0] == 7'h33) || (instr[6:0] == 7'h23) || (instr[6:0] == 7'h63);
            haz = in_valid && slotv && q[0].mr && (q[0].rd != 5'd0) &&
                  ((q[0].rd == instr[19:15]) || (u2 && q[0].rd == instr[24:20]));
            exp_rdy = (!slotv || bus.out_ready) && !haz && !flush;
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            exp_accept = in_valid && exp_rdy;
            pend = model(instr, rd1, rd2, pc_in);
            if (slotv && (flush || bus.out_ready)) void'(q.pop_front());
        end
    end

    // Scoreboard fill: an accepted instruction enters the slot at this edge.
    always @(posedge clk) begin
        if (rst) q.delete();
        else if (exp_accept) q.push_back(pend);
    end

    task automatic issue(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b,
                         output int waits);
        in_valid = 1'b1;
        instr    = w;
        rd1      = a;
        rd2      = b;
        pc_in    = pc_ctr;
        pc_ctr   = pc_ctr + 32'd4;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 50) begin
                chk("issue_timeout", 32'(waits), 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [2:0] pick_f3();
        case ($urandom_range(0, 2))
            0:       return 3'd0;
            1:       return 3'd4;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] im;
        logic [2:0]  f3;
        logic [6:0]  f7;
        rd  = 5'($urandom_range(0, 3));
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        im  = 12'($urandom);
        f3  = 3'($urandom_range(0, 7));
        f7  = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
        case ($urandom_range(0, 9))
            0, 1, 2: begin
                if ($urandom_range(0, 3) != 0) f3 = pick_f3();
                return {f7, rs2, rs1, f3, rd, 7'h33};
            end
            3, 4: begin
                if ($urandom_range(0, 3) != 0) f3 = pick_f3();
                return {im, rs1, f3, rd, 7'h13};
            end
            5, 6: begin
                if ($urandom_range(0, 5) != 0) f3 = 3'd2;
                return {im, rs1, f3, rd, 7'h03};
            end
            7: begin
                if ($urandom_range(0, 5) != 0) f3 = 3'd2;
                return {im[11:5], rs2, rs1, f3, im[4:0], 7'h23};
            end
            8: begin
                if ($urandom_range(0, 5) != 0) f3 = 3'($urandom_range(0, 1));
                return {im[11:5], rs2, rs1, f3, im[4:0], 7'h63};
            end
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int  w;
        logic acc;
        rst           = 1'b1;
        in_valid      = 1'b1;
        instr         = 32'hFFF00293;
        pc_in         = pc_ctr;
        rd1           = 32'h0;
        rd2           = 32'h1234_5678;
        flush         = 1'b0;
        bus.out_ready = 1'b1;

        // Reset with a valid instruction waiting: slot must stay empty and zeroed.
        repeat (2) begin
            @(negedge clk);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_data", bus.SrcA | bus.SrcB | bus.WriteData | bus.ImmExt | bus.pc_out, 32'd0);
            chk("rst_ctrl", 32'({bus.ALUctrl, bus.rd_addr, bus.RegWrite, bus.MemWrite,
                                 bus.MemRead, bus.Branch, bus.BranchNe, bus.illegal}), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_rst_SrcB", bus.SrcB, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        pc_ctr   = pc_ctr + 32'd4;
        @(negedge clk);
        chk("addi_SrcB", bus.SrcB, 32'hFFFF_FFFF);
        chk("addi_ALUctrl", 32'(bus.ALUctrl), 32'd0);
        chk("addi_rd", 32'(bus.rd_addr), 32'd5);
        chk("addi_RegWrite", 32'(bus.RegWrite), 32'd1);

        // add then sub back-to-back.
        issue(32'h002081B3, 32'd7, 32'd5, w);
        issue(32'h402081B3, 32'd7, 32'd5, w);
        chk("sub_no_gap", 32'(w), 32'd0);

        // Load-use: the dependent add must wait exactly one bubble.
        issue(32'h0040A303, 32'd100, 32'd0, w);
        issue(32'h006303B3, 32'd9, 32'd9, w);
        chk("loaduse_wait", 32'(w), 32'd1);

        issue(32'h0020A423, 32'd40, 32'd77, w);
        @(negedge clk);
        chk("sw_ImmExt", bus.ImmExt, 32'd8);
        chk("sw_MemWrite", 32'(bus.MemWrite), 32'd1);
        chk("sw_RegWrite", 32'(bus.RegWrite), 32'd0);

        issue(32'hFE208CE3, 32'd1, 32'd2, w);
        @(negedge clk);
        chk("beq_ImmExt", bus.ImmExt, 32'hFFFF_FFF8);
        chk("beq_ALUctrl", 32'(bus.ALUctrl), 32'd1);
        chk("beq_Branch_Ne", 32'({bus.Branch, bus.BranchNe}), 32'b10);

        issue(32'h0000_0000, 32'd1, 32'd2, w);
        @(negedge clk);
        chk("ill_flag", 32'(bus.illegal), 32'd1);
        chk("ill_ALUctrl", 32'(bus.ALUctrl), 32'd7);

        // Backpressure with a full slot, then a flush while stalled.
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        issue(32'hFFF00293, 32'd3, 32'd4, w);
        in_valid = 1'b1;
        instr    = 32'h002081B3;
        rd1      = 32'd11;
        rd2      = 32'd12;
        pc_in    = pc_ctr;
        pc_ctr   = pc_ctr + 32'd4;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_SrcA", bus.SrcA, 32'd3);
            chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
        end
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid      = 1'b0;
        bus.out_ready = 1'b1;

        // Randomized traffic with backpressure, flushes and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready && !rst;
            @(posedge clk); #1;
            rst           = ($urandom_range(0, 199) == 0);
            flush         = ($urandom_range(0, 29) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (acc || !in_valid) begin
                if ($urandom_range(0, 4) != 0) begin
                    in_valid = 1'b1;
                    instr    = rand_instr();
                    rd1      = $urandom;
                    rd2      = $urandom;
                    pc_in    = pc_ctr;
                    pc_ctr   = pc_ctr + 32'd4;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        rst           = 1'b0;
        flush         = 1'b0;
        in_valid      = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
